// File: rtl/r4_digit_reverse_buf.sv
// Ping-pong reorder buffer: converts radix-4 digit-reversed FFT output to natural bin order.
// Writes land at digit-reversed addresses; a registered read stage streams the full bank out in order.
module r4_digit_reverse_buf #(
  parameter int WL    = 16,
  parameter int LOG4N = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [WL-1:0] in_r,
  input  logic [WL-1:0] in_i,
  output logic          in_ready,
  input  logic          out_ready,
  output logic          out_valid,
  output logic [WL-1:0] out_r,
  output logic [WL-1:0] out_i,
  output logic          out_last,
  output logic          overflow
);

  localparam int AW = 2 * LOG4N;
  localparam int N  = 1 << AW;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} rd_state_t;

  rd_state_t       state, state_nxt;
  logic [2*WL-1:0] mem [2*N];
  logic [AW-1:0]   wcnt;
  logic [AW-1:0]   raddr, raddr_nxt, ld_addr;
  logic            wbank, rbank, rbank_nxt, ld_bank;
  logic            load, rd_free, valid_nxt, wr_en;
  logic [1:0]      full, full_nxt;

  function automatic logic [AW-1:0] digitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int unsigned d = 0; d < LOG4N; d++)
      r[2*d +: 2] = a[2*(LOG4N-1-d) +: 2];
    return r;
  endfunction

  assign in_ready = !full[wbank];
  assign wr_en    = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (wr_en)
      mem[{wbank, digitrev(wcnt)}] <= {in_r, in_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt     <= '0;
      wbank    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        wcnt <= wcnt + 1'b1;
        if (wcnt == '1)
          wbank <= ~wbank;
      end
      if (in_valid && !in_ready)
        overflow <= 1'b1;
    end
  end

  // Fill and free never target the same bank in one cycle: the writer only
  // touches a non-full bank, the reader only frees a full one.
  always_comb begin
    full_nxt = full;
    if (wr_en && wcnt == '1)
      full_nxt[wbank] = 1'b1;
    if (rd_free)
      full_nxt[rbank] = 1'b0;
  end

  always_comb begin
    state_nxt = state;
    raddr_nxt = raddr;
    rbank_nxt = rbank;
    ld_bank   = rbank;
    ld_addr   = raddr;
    load      = 1'b0;
    rd_free   = 1'b0;
    valid_nxt = out_valid;
    unique case (state)
      IDLE: begin
        if (full[rbank]) begin
          state_nxt = STREAM;
          raddr_nxt = '0;
        end
      end
      STREAM: begin
        if (!out_valid || out_ready) begin
          load      = 1'b1;
          valid_nxt = 1'b1;
          raddr_nxt = raddr + 1'b1;
          if (raddr == '1)
            state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (out_valid && out_ready) begin
          rd_free   = 1'b1;
          rbank_nxt = ~rbank;
          // Other bank ready: present its bin 0 now so frames run without a gap.
          if (full[~rbank]) begin
            load      = 1'b1;
            ld_bank   = ~rbank;
            ld_addr   = '0;
            raddr_nxt = {{(AW-1){1'b0}}, 1'b1};
            state_nxt = STREAM;
          end else begin
            valid_nxt = 1'b0;
            raddr_nxt = '0;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      raddr     <= '0;
      rbank     <= 1'b0;
      full      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_r     <= '0;
      out_i     <= '0;
    end else begin
      state     <= state_nxt;
      raddr     <= raddr_nxt;
      rbank     <= rbank_nxt;
      full      <= full_nxt;
      out_valid <= valid_nxt;
      if (load) begin
        {out_r, out_i} <= mem[{ld_bank, ld_addr}];
        out_last       <= (ld_addr == '1);
      end else if (!valid_nxt) begin
        out_last <= 1'b0;
      end
    end
  end

endmodule
